// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine
// Game-state engine for a 32x24-cell snake game. The outer ring of cells is
// wall, and the playfield is x 1..30, y 1..22. The engine moves the snake one
// cell per tick, detects wall, self and food hits, and searches for a new
// food cell with a free-running 16-bit LFSR.
//
// Ports
//   clk                 system clock; all state changes on the rising edge
//   clrn                asynchronous active-low reset
//   tick                move-enable pulse, one clk wide
//   btn_up/down/right/left, btn_start
//                       debounced single-cycle button pulses
//   snake_x_1dim/_y_1dim
//                       segment i occupies bits [5*i +: 5]; i = 0 is the head
//   snake_length        number of active segments (3..63)
//   food_x, food_y      food cell
//   food_display        food valid/visible
//   game_state          RUNNING = 00, DIE = 01, INITIAL = 10
//
// Configuration
//   SNAKE_SELF_COLLIDE_EN   defined: the head running into the body ends the
//                           game. Undefined: only walls end the game.
// -----------------------------------------------------------------------------
module snake_engine (
    input  logic         clk,
    input  logic         clrn,
    input  logic         tick,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_right,
    input  logic         btn_left,
    input  logic         btn_start,
    output logic [319:0] snake_x_1dim,
    output logic [319:0] snake_y_1dim,
    output logic [5:0]   snake_length,
    output logic [4:0]   food_x,
    output logic [4:0]   food_y,
    output logic         food_display,
    output logic [1:0]   game_state
);

    typedef enum logic [1:0] {
        RUNNING = 2'b00,
        DIE     = 2'b01,
        INITIAL = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] RIGHT = 2'b10;
    localparam logic [1:0] LEFT  = 2'b11;

    // Start position (15,12),(14,12),(13,12); every other segment is (0,0).
    localparam logic [319:0] INIT_X = {305'd0, 5'd13, 5'd14, 5'd15};
    localparam logic [319:0] INIT_Y = {305'd0, 5'd12, 5'd12, 5'd12};

    state_t      state;
    logic [1:0]  dir;
    logic [1:0]  pend;
    logic [15:0] lfsr;

    logic [1:0]  new_dir;
    logic [4:0]  head_x, head_y;
    logic [4:0]  next_x, next_y;
    logic [4:0]  cand_x, cand_y;
    logic        wall_hit, self_hit, eat, cand_busy;
    logic [5:0]  new_len;
`ifdef SNAKE_SELF_COLLIDE_EN
    logic [5:0]  body_lim;
`endif

    assign game_state = state;
    assign head_x     = snake_x_1dim[4:0];
    assign head_y     = snake_y_1dim[4:0];

    always_comb begin
        // Flipping bit 0 of the direction code gives the opposite direction,
        // and a pending reversal is dropped.
        new_dir = (pend == (dir ^ 2'b01)) ? dir : pend;
        next_x  = head_x;
        next_y  = head_y;
        case (new_dir)
            UP:      next_y = head_y - 5'd1;
            DOWN:    next_y = head_y + 5'd1;
            RIGHT:   next_x = head_x + 5'd1;
            default: next_x = head_x - 5'd1;
        endcase
        wall_hit = (next_x == 5'd0) || (next_x == 5'd31) ||
                   (next_y == 5'd0) || (next_y == 5'd23);
        eat      = food_display && (next_x == food_x) && (next_y == food_y);
        self_hit = 1'b0;
`ifdef SNAKE_SELF_COLLIDE_EN
        // Without eating, the tail cell is vacated during this move and is
        // therefore not a collision.
        body_lim = eat ? snake_length : snake_length - 6'd1;
        for (int i = 0; i < 64; i++) begin
            if (6'(i) < body_lim &&
                snake_x_1dim[5*i +: 5] == next_x &&
                snake_y_1dim[5*i +: 5] == next_y)
                self_hit = 1'b1;
        end
`endif
        new_len = (eat && snake_length != 6'd63) ? snake_length + 6'd1 : snake_length;

        cand_x    = 5'd1 + (lfsr[4:0] % 5'd30);
        cand_y    = 5'd1 + (lfsr[12:8] % 5'd22);
        cand_busy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (6'(i) < snake_length &&
                snake_x_1dim[5*i +: 5] == cand_x &&
                snake_y_1dim[5*i +: 5] == cand_y)
                cand_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= INITIAL;
            snake_length <= 6'd3;
            snake_x_1dim <= INIT_X;
            snake_y_1dim <= INIT_Y;
            food_x       <= 5'd20;
            food_y       <= 5'd12;
            food_display <= 1'b1;
            dir          <= RIGHT;
            pend         <= RIGHT;
            lfsr         <= 16'hACE1;
        end else begin
            // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

            // The food search runs whenever no food is shown. Each cycle it
            // tries one candidate against the current segments.
            if (!food_display && !cand_busy) begin
                food_x       <= cand_x;
                food_y       <= cand_y;
                food_display <= 1'b1;
            end

            case (state)
                INITIAL: begin
                    if (btn_start) begin
                        state        <= RUNNING;
                        snake_length <= 6'd3;
                        snake_x_1dim <= INIT_X;
                        snake_y_1dim <= INIT_Y;
                        dir          <= RIGHT;
                        pend         <= RIGHT;
                    end
                end
                RUNNING: begin
                    if (tick) begin
                        if (wall_hit || self_hit) begin
                            state <= DIE;
                        end else begin
                            for (int i = 1; i < 64; i++) begin
                                if (6'(i) < new_len) begin
                                    snake_x_1dim[5*i +: 5] <= snake_x_1dim[5*(i-1) +: 5];
                                    snake_y_1dim[5*i +: 5] <= snake_y_1dim[5*(i-1) +: 5];
                                end
                            end
                            snake_x_1dim[4:0] <= next_x;
                            snake_y_1dim[4:0] <= next_y;
                            snake_length      <= new_len;
                            dir               <= new_dir;
                            if (eat)
                                food_display <= 1'b0;
                        end
                    end
                    // A press in the same cycle as a tick is used by the next tick.
                    if (btn_up)
                        pend <= UP;
                    else if (btn_down)
                        pend <= DOWN;
                    else if (btn_right)
                        pend <= RIGHT;
                    else if (btn_left)
                        pend <= LEFT;
                end
                DIE: begin
                    if (btn_start)
                        state <= INITIAL;
                end
                default: state <= INITIAL;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic         tick = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_right = 1'b0, btn_left = 1'b0, btn_start = 1'b0;
    logic [319:0] snake_x_1dim, snake_y_1dim;
    logic [5:0]   snake_length;
    logic [4:0]   food_x, food_y;
    logic         food_display;
    logic [1:0]   game_state;

    snake_engine dut (
        .clk(clk), .clrn(clrn), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_right(btn_right),
        .btn_left(btn_left), .btn_start(btn_start),
        .snake_x_1dim(snake_x_1dim), .snake_y_1dim(snake_y_1dim),
        .snake_length(snake_length), .food_x(food_x), .food_y(food_y),
        .food_display(food_display), .game_state(game_state)
    );

    always #5 clk = ~clk;

`ifdef SNAKE_SELF_COLLIDE_EN
    localparam bit SELF = 1'b1;
`else
    localparam bit SELF = 1'b0;
`endif

    // Reference model: states 0 run, 1 die, 2 initial; directions 0 up, 1 down, 2 right, 3 left
    int          mx[64], my[64];
    int          mlen, mstate, mdir, mpend, mfx, mfy;
    bit          mfd;
    logic [15:0] mlfsr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int dx(int d);
        return (d == 2) ? 1 : (d == 3) ? -1 : 0;
    endfunction
    function automatic int dy(int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction
    function automatic int opp(int d);
        case (d) 0: return 1; 1: return 0; 2: return 3; default: return 2; endcase
    endfunction
    function automatic int ccw(int d);
        case (d) 2: return 0; 0: return 3; 3: return 1; default: return 2; endcase
    endfunction

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        int  taps[4] = '{16, 14, 13, 11};
        bit  fb = 1'b0;
        foreach (taps[k]) fb ^= v[16 - taps[k]];
        return {fb, v[15:1]};
    endfunction

    function automatic bit occupied(int x, int y, int n);
        for (int i = 0; i < n; i++)
            if (mx[i] == x && my[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_snake();
        for (int i = 0; i < 64; i++) begin mx[i] = 0; my[i] = 0; end
        mx[0] = 15; mx[1] = 14; mx[2] = 13;
        my[0] = 12; my[1] = 12; my[2] = 12;
        mlen = 3; mdir = 2; mpend = 2;
    endtask

    task automatic model_reset();
        load_snake();
        mstate = 2; mfx = 20; mfy = 12; mfd = 1'b1; mlfsr = 16'hACE1;
    endtask

    task automatic model_step(input bit t, input bit u, input bit d, input bit r, input bit l, input bit s);
        int cx, cy, nd, nx, ny, lim, nl, nfx, nfy;
        bit eat, hit, nfd;
        nfd = mfd; nfx = mfx; nfy = mfy;
        cx = 1 + (int'(mlfsr[4:0]) % 30);
        cy = 1 + (int'(mlfsr[12:8]) % 22);
        if (!mfd && !occupied(cx, cy, mlen)) begin nfd = 1'b1; nfx = cx; nfy = cy; end
        case (mstate)
            2: if (s) begin load_snake(); mstate = 0; end
            0: begin
                if (t) begin
                    nd  = (mpend == opp(mdir)) ? mdir : mpend;
                    nx  = mx[0] + dx(nd);
                    ny  = my[0] + dy(nd);
                    eat = mfd && nx == mfx && ny == mfy;
                    hit = nx < 1 || nx > 30 || ny < 1 || ny > 22;
                    lim = eat ? mlen : mlen - 1;
                    if (SELF && occupied(nx, ny, lim)) hit = 1'b1;
                    if (hit) mstate = 1;
                    else begin
                        nl = (eat && mlen < 63) ? mlen + 1 : mlen;
                        for (int i = nl - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
                        mx[0] = nx; my[0] = ny; mlen = nl; mdir = nd;
                        if (eat) nfd = 1'b0;
                    end
                end
                if (u) mpend = 0; else if (d) mpend = 1; else if (r) mpend = 2; else if (l) mpend = 3;
            end
            1: if (s) mstate = 2;
            default: mstate = 2;
        endcase
        mfd = nfd; mfx = nfx; mfy = nfy;
        mlfsr = lfsr_next(mlfsr);
    endtask

    task automatic compare_all();
        logic [319:0] ex, ey;
        ex = '0; ey = '0;
        for (int i = 0; i < 64; i++) begin
            ex[5*i +: 5] = 5'(mx[i]);
            ey[5*i +: 5] = 5'(my[i]);
        end
        check("game_state",   320'(game_state),   320'(mstate));
        check("snake_length", 320'(snake_length), 320'(mlen));
        check("snake_x",      snake_x_1dim,       ex);
        check("snake_y",      snake_y_1dim,       ey);
        check("food_display", 320'(food_display), 320'(mfd));
        check("food_x",       320'(food_x),       320'(mfx));
        check("food_y",       320'(food_y),       320'(mfy));
    endtask

    task automatic cyc(input bit t, input bit u, input bit d, input bit r, input bit l, input bit s);
        @(negedge clk);
        clrn = 1'b1;
        tick = t; btn_up = u; btn_down = d; btn_right = r; btn_left = l; btn_start = s;
        @(posedge clk);
        model_step(t, u, d, r, l, s);
        #1 compare_all();
    endtask

    // Reset is asserted between edges so its effect must be visible without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        clrn = 1'b0;
        tick = 0; btn_up = 0; btn_down = 0; btn_right = 0; btn_left = 0; btn_start = 0;
        model_reset();
        #1;
        check("rst_state",  320'(game_state),   320'(2));
        check("rst_len",    320'(snake_length), 320'(3));
        check("rst_food_x", 320'(food_x),       320'(20));
        check("rst_food_y", 320'(food_y),       320'(12));
        check("rst_food_d", 320'(food_display), 320'(1));
        compare_all();
        @(posedge clk);
        #1 compare_all();
    endtask

    task automatic move(input int d);
        cyc(0, d == 0, d == 1, d == 2, d == 3, 0);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick(int tx, int ty);
        int q[$];
        int nx, ny;
        if (tx > mx[0]) q.push_back(2);
        if (tx < mx[0]) q.push_back(3);
        if (ty < my[0]) q.push_back(0);
        if (ty > my[0]) q.push_back(1);
        for (int d = 0; d < 4; d++) q.push_back(d);
        foreach (q[k]) begin
            nx = mx[0] + dx(q[k]);
            ny = my[0] + dy(q[k]);
            if (q[k] != opp(mdir) && nx >= 1 && nx <= 30 && ny >= 1 && ny <= 22 && !occupied(nx, ny, mlen))
                return q[k];
        end
        return mdir;
    endfunction

    function automatic bit dut_on_body(logic [4:0] x, logic [4:0] y, int from);
        for (int i = from; i < int'(snake_length); i++)
            if (snake_x_1dim[5*i +: 5] == x && snake_y_1dim[5*i +: 5] == y) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  budget, d, waited;
        bit  in_range;
        model_reset();

        // Start and three plain ticks
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        check("run_state", 320'(game_state), 320'(0));
        check("head_x_18", 320'(snake_x_1dim[4:0]), 320'(18));
        check("tail_x_16", 320'(snake_x_1dim[14:10]), 320'(16));

        // Reversal rejected, then a legal turn
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rev_head_x", 320'(snake_x_1dim[4:0]), 320'(19));
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("up_head_y", 320'(snake_y_1dim[4:0]), 320'(11));

        // Eat the reset food at (20,12) and wait for the replacement
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        check("eat_len",    320'(snake_length), 320'(4));
        check("eat_head_x", 320'(snake_x_1dim[4:0]), 320'(20));
        check("eat_fd_off", 320'(food_display), 320'(0));
        waited = 0;
        while (!food_display && waited < 200) begin cyc(0, 0, 0, 0, 0, 0); waited++; end
        check("food_found", 320'(food_display), 320'(1));
        in_range = food_x >= 5'd1 && food_x <= 5'd30 && food_y >= 5'd1 && food_y <= 5'd22;
        check("food_range", 320'(in_range), 320'(1));
        check("food_off_snake", 320'(dut_on_body(food_x, food_y, 0)), 320'(0));

        // Reset in the middle of a food search
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        check("mid_search_fd", 320'(food_display), 320'(0));
        do_reset();

        // Run into the right wall, then restart
        cyc(0, 0, 0, 0, 0, 1);
        repeat (15) cyc(1, 0, 0, 0, 0, 0);
        check("wall_pre_state", 320'(game_state), 320'(0));
        check("wall_pre_x", 320'(snake_x_1dim[4:0]), 320'(30));
        cyc(1, 0, 0, 0, 0, 0);
        check("wall_die", 320'(game_state), 320'(1));
        check("wall_frozen_x", 320'(snake_x_1dim[4:0]), 320'(30));
        cyc(0, 0, 0, 0, 0, 1);
        check("die_to_init", 320'(game_state), 320'(2));
        cyc(1, 0, 0, 0, 0, 1);
        check("tick_start_state", 320'(game_state), 320'(0));
        check("tick_start_no_move", 320'(snake_x_1dim[4:0]), 320'(15));

        // Grow to length >= 5, get into open space, then loop into the body
        budget = 0;
        while ((mlen < 5 || mx[0] < 8 || mx[0] > 23 || my[0] < 8 || my[0] > 15) && budget < 400 && mstate == 0) begin
            if (mlen < 5 && mfd) d = pick(mfx, mfy);
            else d = pick(15, 12);
            move(d);
            budget++;
        end
        for (int k = 0; k < 6 && mstate == 0; k++) cyc(1, 0, 0, 0, 0, 0);
        check("loop_len", 320'(snake_length >= 6'd5), 320'(1));
        check("loop_pre_state", 320'(game_state), 320'(0));
        d = mdir;
        for (int k = 0; k < 3; k++) begin d = ccw(d); move(d); end
        check("loop_state", 320'(game_state), 320'(SELF ? 1 : 0));
        check("loop_overlap", 320'(dut_on_body(snake_x_1dim[4:0], snake_y_1dim[4:0], 1)), 320'(!SELF));

        // Randomized play against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
